// File: rtl/t_state_sequencer_if.sv
// Sequencer <-> datapath/pin bundle: rdy and data pins in, address value and
// control strobes out.
interface t_state_sequencer_if;
    logic        rdy;
    logic [7:0]  din;
    logic [15:0] ab_drive;
    logic        ctl_pc_adl, ctl_pc_adh, ctl_adl_abl, ctl_adh_abh;
    logic        ctl_dl_db, ctl_sb_db, ctl_ac_sb, ctl_x_sb, ctl_y_sb;
    logic        ctl_sb_ac, ctl_sb_x, ctl_sb_y;
    logic        sync, halted;

    modport master (
        input  rdy, din,
        output ab_drive,
        output ctl_pc_adl, ctl_pc_adh, ctl_adl_abl, ctl_adh_abh,
        output ctl_dl_db, ctl_sb_db, ctl_ac_sb, ctl_x_sb, ctl_y_sb,
        output ctl_sb_ac, ctl_sb_x, ctl_sb_y,
        output sync, halted
    );

    modport slave (
        output rdy, din,
        input  ab_drive,
        input  ctl_pc_adl, ctl_pc_adh, ctl_adl_abl, ctl_adh_abh,
        input  ctl_dl_db, ctl_sb_db, ctl_ac_sb, ctl_x_sb, ctl_y_sb,
        input  ctl_sb_ac, ctl_sb_x, ctl_sb_y,
        input  sync, halted
    );
endinterface

// File: rtl/t_state_sequencer.sv
// 6502 cycle sequencer: PC, IR and T-state FSM for the reset vector fetch and a
// small instruction subset (LDA/LDX/LDY #imm, TAX, TAY, TXA, TYA, NOP).
module t_state_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic              ph0,
    input  logic              reset,
    t_state_sequencer_if.master bus
);
    localparam logic [2:0] RST0  = 3'd0;
    localparam logic [2:0] RST1  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] OPER  = 3'd3;
    localparam logic [2:0] EXEC  = 3'd4;
    localparam logic [2:0] HALT  = 3'd5;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_A    = 2'd1;
    localparam logic [1:0] WB_X    = 2'd2;
    localparam logic [1:0] WB_Y    = 2'd3;

    typedef struct packed {
        logic pc_adl, pc_adh, adl_abl, adh_abh;
        logic dl_db, sb_db, ac_sb, x_sb, y_sb;
        logic sb_ac, sb_x, sb_y;
        logic sync, halted;
    } ctl_t;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [1:0]  wb_q, wb_d;
    ctl_t        ctl;
    logic [15:0] ab;

    // Moore decode: registers only; rdy gates the load strobes further down.
    always_comb begin
        ctl = '0;
        ab  = pc_q;
        if (state_q != HALT && state_q <= HALT) begin
            ctl.pc_adl  = 1'b1;
            ctl.pc_adh  = 1'b1;
            ctl.adl_abl = 1'b1;
            ctl.adh_abh = 1'b1;
        end
        case (state_q)
            RST0: ab = RESET_VECTOR;
            RST1: ab = RESET_VECTOR + 16'd1;
            FETCH: begin
                ctl.sync = 1'b1;
                if (wb_q != WB_NONE) begin
                    ctl.dl_db = 1'b1;
                    ctl.sb_db = 1'b1;
                    ctl.sb_ac = (wb_q == WB_A);
                    ctl.sb_x  = (wb_q == WB_X);
                    ctl.sb_y  = (wb_q == WB_Y);
                end
            end
            OPER: ;
            EXEC: begin
                case (ir_q)
                    8'hAA:   begin ctl.ac_sb = 1'b1; ctl.sb_x  = 1'b1; end
                    8'hA8:   begin ctl.ac_sb = 1'b1; ctl.sb_y  = 1'b1; end
                    8'h8A:   begin ctl.x_sb  = 1'b1; ctl.sb_ac = 1'b1; end
                    8'h98:   begin ctl.y_sb  = 1'b1; ctl.sb_ac = 1'b1; end
                    default: ;
                endcase
            end
            default: ctl.halted = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wb_d    = wb_q;
        if (bus.rdy) begin
            case (state_q)
                RST0: begin
                    pc_d[7:0] = bus.din;
                    state_d   = RST1;
                end
                RST1: begin
                    pc_d[15:8] = bus.din;
                    state_d    = FETCH;
                end
                FETCH: begin
                    ir_d = bus.din;
                    pc_d = pc_q + 16'd1;
                    wb_d = WB_NONE;
                    case (bus.din)
                        8'hA9, 8'hA2, 8'hA0:               state_d = OPER;
                        8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hEA: state_d = EXEC;
                        default:                           state_d = HALT;
                    endcase
                end
                OPER: begin
                    pc_d = pc_q + 16'd1;
                    case (ir_q)
                        8'hA9:   wb_d = WB_A;
                        8'hA2:   wb_d = WB_X;
                        8'hA0:   wb_d = WB_Y;
                        default: wb_d = WB_NONE;
                    endcase
                    state_d = FETCH;
                end
                EXEC:    state_d = FETCH;
                default: state_d = HALT;
            endcase
        end
    end

    always_ff @(posedge ph0) begin
        if (reset) begin
            state_q <= RST0;
            pc_q    <= 16'h0000;
            ir_q    <= 8'hEA;
            wb_q    <= WB_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wb_q    <= wb_d;
        end
    end

    assign bus.ab_drive    = ab;
    assign bus.ctl_pc_adl  = ctl.pc_adl;
    assign bus.ctl_pc_adh  = ctl.pc_adh;
    assign bus.ctl_adl_abl = ctl.adl_abl;
    assign bus.ctl_adh_abh = ctl.adh_abh;
    assign bus.ctl_dl_db   = ctl.dl_db;
    assign bus.ctl_sb_db   = ctl.sb_db;
    assign bus.ctl_ac_sb   = ctl.ac_sb;
    assign bus.ctl_x_sb    = ctl.x_sb;
    assign bus.ctl_y_sb    = ctl.y_sb;
    // A stalled cycle repeats, so register loads fire only on its final rdy=1 pass.
    assign bus.ctl_sb_ac   = ctl.sb_ac & bus.rdy;
    assign bus.ctl_sb_x    = ctl.sb_x  & bus.rdy;
    assign bus.ctl_sb_y    = ctl.sb_y  & bus.rdy;
    assign bus.sync        = ctl.sync;
    assign bus.halted      = ctl.halted;
endmodule
